// File: rtl/axi_wr_burst_gen.sv
// axi_wr_burst_gen: splits a (start address, beat count) write command into
// AXI4 INCR bursts with one burst outstanding at a time. The W channel is a
// zero-latency passthrough of the s_* beat stream.
// Optional build macro: AXI_WR_4K_SPLIT_EN -- when defined, no burst crosses
// a 4 KB address boundary; otherwise bursts are capped by MAX_BURST only.
module axi_wr_burst_gen #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 64
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [23:0]             cmd_beats,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    done,
  output logic                    busy,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     axi_awid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic                    axi_bvalid,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_bready
);
  localparam int BPB   = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BPB);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                  state;
  logic [23:0]             rem;       // beats not yet assigned to a burst
  logic [8:0]              len_q;     // beats in the current burst
  logic [7:0]              beat_cnt;  // beats sent in the current burst
  logic [ADDR_WIDTH-1:0]   cmd_addr_al;
  logic [12:0]             b4k_cmd;   // beats left before 4 KB, for a new command
  logic [12:0]             b4k_cur;   // same, for the next burst of this command
  logic                    w_hs;

  assign cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(BPB - 1);

`ifdef AXI_WR_4K_SPLIT_EN
  assign b4k_cmd = (13'd4096 - {1'b0, cmd_addr_al[11:0]}) >> ALIGN;
  assign b4k_cur = (13'd4096 - {1'b0, axi_awaddr[11:0]}) >> ALIGN;
`else
  // Larger than any legal burst, so the boundary term never limits.
  assign b4k_cmd = '1;
  assign b4k_cur = '1;
`endif

  // len = min(rem, MAX_BURST, beats to 4 KB); MAX_BURST <= 256 fits in 9 bits
  function automatic logic [8:0] calc_len(input logic [23:0] r, input logic [12:0] b4k);
    logic [8:0] l;
    l = (r > 24'(MAX_BURST)) ? 9'(MAX_BURST) : r[8:0];
    if (b4k < {4'd0, l}) l = b4k[8:0];
    return l;
  endfunction

  assign axi_awid    = ID_WIDTH'(AXI_ID);
  assign axi_awsize  = 3'(ALIGN);
  assign axi_awburst = 2'b01;
  assign axi_wstrb   = '1;
  assign axi_wdata   = s_data;
  assign axi_wvalid  = (state == S_W) && s_valid;
  assign s_ready     = (state == S_W) && axi_wready;
  assign axi_wlast   = (state == S_W) && ({1'b0, beat_cnt} == len_q - 9'd1);
  assign w_hs        = axi_wvalid && axi_wready;

  // Command / burst sequencer with registered handshake and status outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rem         <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awvalid <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            err        <= 1'b0;
            axi_awaddr <= cmd_addr_al;
            rem        <= cmd_beats;
            if (cmd_beats == 24'd0) begin
              done <= 1'b1;
            end else begin
              len_q       <= calc_len(cmd_beats, b4k_cmd);
              axi_awlen   <= 8'(calc_len(cmd_beats, b4k_cmd) - 9'd1);
              axi_awvalid <= 1'b1;
              cmd_ready   <= 1'b0;
              busy        <= 1'b1;
              state       <= S_AW;
            end
          end
        end
        S_AW: begin
          if (axi_awready) begin
            // awaddr is free to advance once the address is accepted
            axi_awvalid <= 1'b0;
            axi_awaddr  <= axi_awaddr + (ADDR_WIDTH'(len_q) << ALIGN);
            rem         <= rem - 24'(len_q);
            beat_cnt    <= '0;
            state       <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (axi_wlast) begin
              axi_bready <= 1'b1;
              state      <= S_B;
            end
          end
        end
        S_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            if (axi_bresp != 2'b00) err <= 1'b1;
            if (rem == 24'd0) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              len_q       <= calc_len(rem, b4k_cur);
              axi_awlen   <= 8'(calc_len(rem, b4k_cur) - 9'd1);
              axi_awvalid <= 1'b1;
              state       <= S_AW;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Randomized self-checking bench for axi_wr_burst_gen (default parameters).
// Expected bursts come from a loop over the splitting rules; expected data is
// the stream the bench itself sourced.
module tb_axi_wr_burst_gen;
  localparam int AW   = 29;
  localparam int DW   = 256;
  localparam int BPB  = DW / 8;
  localparam int MAXB = 64;

  logic            clock = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [23:0]     cmd_beats;
  logic            s_valid, s_ready;
  logic [DW-1:0]   s_data;
  logic            done, busy, err;
  logic [3:0]      axi_awid;
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  logic [1:0]      axi_awburst;
  logic            axi_awvalid, axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [BPB-1:0]  axi_wstrb;
  logic            axi_wlast, axi_wvalid, axi_wready;
  logic            axi_bvalid;
  logic [1:0]      axi_bresp;
  logic            axi_bready;

  axi_wr_burst_gen dut (
    .clock(clock), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .done(done), .busy(busy), .err(err),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  typedef struct { logic [AW-1:0] a; int len; } burst_t;

  logic [DW-1:0] dat[$];
  burst_t        exp_q[$];
  logic [1:0]    bresp_tab[$];
  int            n_beats = 0, s_idx = 0, w_idx = 0, b_idx = 0;
  int            aw_seen = 0, cur_len = 0, beat_in = 0, done_cnt = 0;
  bit            stall = 0, w_hs_flag = 0, b_hs_flag = 0;
  logic          pv_awvalid = 0, pv_awready = 0;
  logic [AW-1:0] pv_awaddr;
  logic [7:0]    pv_awlen;

  // Reference burst list from the splitting rules
  task automatic build_exp(input logic [AW-1:0] addr, input int beats);
    logic [AW-1:0] a;
    int r, l;
    burst_t b;
    exp_q = {};
    a = addr & ~AW'(BPB - 1);
    r = beats;
    while (r > 0) begin
      l = (r < MAXB) ? r : MAXB;
`ifdef AXI_WR_4K_SPLIT_EN
      if ((4096 - int'(a[11:0])) / BPB < l) l = (4096 - int'(a[11:0])) / BPB;
`endif
      b.a = a;
      b.len = l;
      exp_q.push_back(b);
      a = a + AW'(l * BPB);
      r -= l;
    end
  endtask

  // Monitor: values at the falling edge are those the next rising edge sees
  always @(negedge clock) begin
    burst_t b;
    if (rst) begin
      pv_awvalid = 0;
    end else begin
      if (pv_awvalid && !pv_awready) begin
        chk("aw_hold_valid", axi_awvalid, 1);
        chk("aw_hold_addr", axi_awaddr, pv_awaddr);
        chk("aw_hold_len", axi_awlen, pv_awlen);
      end
      if (axi_awvalid) chk("aw_w_overlap", axi_wvalid, 0);
      if (axi_awvalid && axi_awready) begin
        if (exp_q.size() == 0) chk("aw_extra", 1, 0);
        else begin
          b = exp_q.pop_front();
          chk("awaddr", axi_awaddr, b.a);
          chk("awlen", axi_awlen, b.len - 1);
          cur_len = b.len;
        end
        beat_in = 0;
        aw_seen++;
      end
      if (axi_wvalid && axi_wready) begin
        if (w_idx < n_beats) chk("wdata", axi_wdata, dat[w_idx]);
        else chk("w_extra", 1, 0);
        chk("wlast", axi_wlast, (beat_in == cur_len - 1));
        beat_in++;
        w_idx++;
        w_hs_flag = 1;
      end
      if (axi_bvalid && axi_bready) b_hs_flag = 1;
      if (done) done_cnt++;
      pv_awvalid = axi_awvalid;
      pv_awready = axi_awready;
      pv_awaddr  = axi_awaddr;
      pv_awlen   = axi_awlen;
    end
  end

  // Downstream / source driver, updated just after each rising edge
  always @(posedge clock) begin
    #1;
    if (rst) begin
      s_valid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
      w_hs_flag = 0; b_hs_flag = 0;
    end else begin
      if (w_hs_flag) begin s_idx++; w_hs_flag = 0; end
      s_valid = (s_idx < n_beats) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      s_data  = (s_idx < n_beats) ? dat[s_idx] : '0;
      axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (b_hs_flag) begin
        axi_bvalid = 0; axi_bresp = 0; b_hs_flag = 0; b_idx++;
      end else if (axi_bready && !axi_bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
        axi_bvalid = 1;
        axi_bresp  = (b_idx < bresp_tab.size()) ? bresp_tab[b_idx] : 2'b00;
      end
    end
  end

  task automatic run_cmd(input logic [AW-1:0] addr, input int beats, input bit stall_i,
                         input logic [1:0] first_resp);
    int nb, cyc;
    bit got;
    logic [DW-1:0] d;
    @(posedge clock); #2;
    dat = {};
    for (int i = 0; i < beats; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      dat.push_back(d);
    end
    build_exp(addr, beats);
    nb = exp_q.size();
    bresp_tab = {};
    bresp_tab.push_back(first_resp);
    n_beats = beats; s_idx = 0; w_idx = 0; b_idx = 0; aw_seen = 0; done_cnt = 0;
    stall = stall_i;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_addr = addr; cmd_beats = 24'(beats); cmd_valid = 1;
    @(posedge clock); #2;
    cmd_valid = 0;
    @(negedge clock);
    chk("err_clr_on_accept", err, 0);
    if (beats == 0) begin
      chk("zero_done", done, 1);
      chk("zero_awvalid", axi_awvalid, 0);
      got = done;
    end else begin
      chk("accept_busy", busy, 1);
      chk("accept_awvalid", axi_awvalid, 1);
      chk("accept_cmd_ready", cmd_ready, 0);
      got = 0;
      cyc = 0;
      while (!got && cyc < 20000) begin
        @(negedge clock);
        got = done;
        cyc++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_err", err, (first_resp != 2'b00));
    @(negedge clock);
    chk("done_pulse_1cyc", done, 0);
    @(negedge clock);
    chk("done_count", done_cnt, 1);
    chk("burst_count", aw_seen, nb);
    chk("beat_count", w_idx, beats);
    stall = 0;
  endtask

  initial begin
    int cyc;
    rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_beats = '0;
    s_valid = 0; s_data = '0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_wlast", axi_wlast, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_awlen", axi_awlen, 0);
    chk("awid", axi_awid, 0);
    chk("awsize", axi_awsize, 5);
    chk("awburst", axi_awburst, 1);
    chk("wstrb", axi_wstrb, {BPB{1'b1}});
    @(posedge clock); #2;
    rst = 0;

    run_cmd(29'h0, 16, 0, 2'b00);
    run_cmd(29'h0, 200, 0, 2'b00);
    run_cmd(29'hF80, 10, 0, 2'b00);
    run_cmd(29'h0000_0F8C, 10, 1, 2'b00);                     // unaligned low bits
    run_cmd(AW'($urandom) & 29'h1FFF_FFE0, 32, 1, 2'b00);
    run_cmd(29'h0, 100, 0, 2'b10);                             // error on first burst
    run_cmd(29'h2000, 5, 0, 2'b00);                            // err clears on accept
    run_cmd(29'h123, 0, 0, 2'b00);                             // zero beats
    run_cmd(29'h1FFF_FFC0, 8, 1, 2'b00);                       // address wrap
    for (int t = 0; t < 6; t++)
      run_cmd(AW'($urandom), $urandom_range(1, 150), 1'($urandom_range(0, 1)), 2'b00);

    // Reset while the W channel is active
    @(posedge clock); #2;
    dat = {};
    for (int i = 0; i < 32; i++) dat.push_back({8{$urandom}});
    build_exp(29'h40, 32);
    n_beats = 32; s_idx = 0; w_idx = 0; b_idx = 0; aw_seen = 0; stall = 1;
    bresp_tab = {};
    cmd_addr = 29'h40; cmd_beats = 24'd32; cmd_valid = 1;
    @(posedge clock); #2;
    cmd_valid = 0;
    cyc = 0;
    while (w_idx < 3 && cyc < 2000) begin @(negedge clock); cyc++; end
    if (w_idx < 3) chk("midw_timeout", 0, 1);
    #2 rst = 1;
    #1;
    chk("midw_cmd_ready", cmd_ready, 1);
    chk("midw_busy", busy, 0);
    chk("midw_awvalid", axi_awvalid, 0);
    chk("midw_wvalid", axi_wvalid, 0);
    chk("midw_s_ready", s_ready, 0);
    chk("midw_wlast", axi_wlast, 0);
    chk("midw_bready", axi_bready, 0);
    chk("midw_done", done, 0);
    chk("midw_awaddr", axi_awaddr, 0);
    chk("midw_awlen", axi_awlen, 0);
    repeat (2) @(posedge clock);
    #3 rst = 0;
    run_cmd(29'h3000, 20, 1, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
